// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 prefix bytes, key/parser state encodings and sizing helper.
package ps2_pkg;

   localparam logic [7:0] RELEASE_PREFIX = 8'hF0;
   localparam logic [7:0] EXTEND_PREFIX  = 8'hE0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESSED  = 2'd1,
      RELEASED = 2'd2
   } key_state_e;

   typedef enum logic [1:0] {
      BASE      = 2'd0,
      EXT       = 2'd1,
      BREAK     = 2'd2,
      EXT_BREAK = 2'd3
   } parse_state_e;

   function automatic int key_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ps2_key_slot.sv
// rtl/ps2_key_slot.sv - one tracked key: held level, acknowledged state and transition event.
module ps2_key_slot
   import ps2_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       match_i,
   input  logic       make_i,
   input  logic       break_i,
   input  logic       clear_i,
   output logic       key_down_o,
   output logic [1:0] key_state_o,
   output logic       event_o
);

   logic       down_q, down_d;
   key_state_e state_q, state_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         down_q  <= 1'b0;
         state_q <= IDLE;
      end else begin
         down_q  <= down_d;
         state_q <= state_d;
      end
   end

   // A transition on this key takes priority over its acknowledge; repeats fall through to the clear.
   always_comb begin
      down_d  = down_q;
      state_d = state_q;
      event_o = 1'b0;
      if (match_i && break_i) begin
         down_d  = 1'b0;
         state_d = RELEASED;
         event_o = 1'b1;
      end else if (match_i && make_i && !down_q) begin
         down_d  = 1'b1;
         state_d = PRESSED;
         event_o = 1'b1;
      end else if (clear_i) begin
         state_d = IDLE;
      end
   end

   assign key_down_o  = down_q;
   assign key_state_o = state_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 make/break parser with prefix timeout feeding N key slots.
// Build option: define PS2_KEY_EXTENDED_EN to decode E0 extended codes.
module ps2_key_tracker
   import ps2_pkg::*;
#(
   parameter int                    NUM_KEYS       = 4,
   parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h076, 9'h172, 9'h175, 9'h029},
   parameter int                    TIMEOUT_CYCLES = 2_500_000
) (
   input  logic                             inclock,
   input  logic                             reset,
   input  logic [7:0]                       received_data,
   input  logic                             received_data_en,
   input  logic [NUM_KEYS-1:0]              state_clear,
   output logic [2*NUM_KEYS-1:0]            key_state,
   output logic [NUM_KEYS-1:0]              key_down,
   output logic                             event_valid,
   output logic [key_idx_w(NUM_KEYS)-1:0]   event_key,
   output logic                             event_release
);

   localparam int          KEY_W    = key_idx_w(NUM_KEYS);
   localparam logic [31:0] TMO_LAST = 32'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   parse_state_e        state_q, state_d;
   logic [31:0]         tmo_q, tmo_d;
   logic                tmo_expire;
   logic                is_prefix;
   logic                make_stb, break_stb;
   logic [NUM_KEYS-1:0] match, slot_ev;
   logic                ev_valid_q, ev_valid_d;
   logic                ev_rel_q, ev_rel_d;
   logic [KEY_W-1:0]    ev_key_q, ev_key_d;
`ifdef PS2_KEY_EXTENDED_EN
   logic                ext_flag;
`endif

   assign is_prefix  = (received_data == RELEASE_PREFIX) || (received_data == EXTEND_PREFIX);
   assign tmo_expire = (TIMEOUT_CYCLES != 0) && (state_q != BASE) && (tmo_q == TMO_LAST);

   always_ff @(posedge inclock) begin
      if (reset) state_q <= BASE;
      else       state_q <= state_d;
   end

   // A byte arriving on the expiry cycle is still decoded in the prefix state.
   always_comb begin
      state_d = state_q;
      if (received_data_en) begin
         case (state_q)
            BASE: begin
               if (received_data == RELEASE_PREFIX) state_d = BREAK;
`ifdef PS2_KEY_EXTENDED_EN
               else if (received_data == EXTEND_PREFIX) state_d = EXT;
            end
            EXT: begin
               if (received_data == RELEASE_PREFIX)     state_d = EXT_BREAK;
               else if (received_data == EXTEND_PREFIX) state_d = EXT;
               else                                     state_d = BASE;
`endif
            end
            default: state_d = BASE;
         endcase
      end else if (tmo_expire) begin
         state_d = BASE;
      end
   end

   always_comb begin
      make_stb  = 1'b0;
      break_stb = 1'b0;
`ifdef PS2_KEY_EXTENDED_EN
      ext_flag  = 1'b0;
`endif
      if (received_data_en) begin
         case (state_q)
            BASE:  make_stb  = !is_prefix;
            BREAK: break_stb = 1'b1;
`ifdef PS2_KEY_EXTENDED_EN
            EXT: begin
               make_stb = !is_prefix;
               ext_flag = 1'b1;
            end
            EXT_BREAK: begin
               break_stb = 1'b1;
               ext_flag  = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      if (received_data_en || (state_q == BASE) || tmo_expire) tmo_d = 32'd0;
      else                                                     tmo_d = tmo_q + 32'd1;
   end

   always_ff @(posedge inclock) begin
      if (reset) tmo_q <= 32'd0;
      else       tmo_q <= tmo_d;
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_slot
`ifdef PS2_KEY_EXTENDED_EN
      assign match[i] = ({ext_flag, received_data} == KEY_CODES[9*i +: 9]);
`else
      assign match[i] = (received_data == KEY_CODES[9*i +: 8]);
`endif
      ps2_key_slot u_slot (
         .clk_i       (inclock),
         .reset_i     (reset),
         .match_i     (match[i]),
         .make_i      (make_stb),
         .break_i     (break_stb),
         .clear_i     (state_clear[i]),
         .key_down_o  (key_down[i]),
         .key_state_o (key_state[2*i +: 2]),
         .event_o     (slot_ev[i])
      );
   end

   // Descending scan so the lowest matching slot is the one reported.
   always_comb begin
      ev_valid_d = |slot_ev;
      ev_key_d   = ev_key_q;
      ev_rel_d   = ev_rel_q;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (slot_ev[i]) begin
            ev_key_d = KEY_W'(i);
            ev_rel_d = break_stb;
         end
      end
   end

   always_ff @(posedge inclock) begin
      if (reset) begin
         ev_valid_q <= 1'b0;
         ev_key_q   <= '0;
         ev_rel_q   <= 1'b0;
      end else begin
         ev_valid_q <= ev_valid_d;
         ev_key_q   <= ev_key_d;
         ev_rel_q   <= ev_rel_d;
      end
   end

   assign event_valid   = ev_valid_q;
   assign event_key     = ev_key_q;
   assign event_release = ev_rel_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - directed and randomized bench for ps2_key_tracker against a byte-level model.
module tb_ps2_key_tracker;

   localparam int NK  = 4;
   localparam int TMO = 100;
   localparam logic [9*NK-1:0] CODES = {9'h076, 9'h172, 9'h175, 9'h029};
`ifdef PS2_KEY_EXTENDED_EN
   localparam bit EXT_EN = 1'b1;
`else
   localparam bit EXT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rd = 8'h00;
   logic          rd_en = 1'b0;
   logic [NK-1:0] clr = '0;
   logic [2*NK-1:0] ks;
   logic [NK-1:0]   kd;
   logic            ev_v;
   logic [1:0]      ev_k;
   logic            ev_r;

   always #5 clk = ~clk;

   ps2_key_tracker #(.NUM_KEYS(NK), .KEY_CODES(CODES), .TIMEOUT_CYCLES(TMO)) dut (
      .inclock          (clk),
      .reset            (rst),
      .received_data    (rd),
      .received_data_en (rd_en),
      .state_clear      (clr),
      .key_state        (ks),
      .key_down         (kd),
      .event_valid      (ev_v),
      .event_key        (ev_k),
      .event_release    (ev_r)
   );

   int pass_cnt = 0;
   int total_cnt = 0;

   // Model: pending prefixes as flags, idle cycles since the last byte, per-key arrays.
   int m_state[NK];
   bit m_down[NK];
   bit m_valid, m_rel;
   int m_key;
   bit pend_brk, pend_ext;
   int idle;

   function automatic logic [3*NK+3:0] exp_vec();
      logic [2*NK-1:0] s;
      logic [NK-1:0]   d;
      for (int i = 0; i < NK; i++) begin
         s[2*i +: 2] = 2'(m_state[i]);
         d[i]        = m_down[i];
      end
      return {s, d, m_valid, 2'(m_key), m_rel};
   endfunction

   task automatic model_step(input bit r, input bit en, input logic [7:0] b, input logic [NK-1:0] c);
      bit is_make, is_brk, ext, any, hit, match;
      logic [8:0] code;
      m_valid = 0;
      if (r) begin
         for (int i = 0; i < NK; i++) begin m_state[i] = 0; m_down[i] = 0; end
         m_key = 0; m_rel = 0; pend_brk = 0; pend_ext = 0; idle = 0;
         return;
      end
      is_make = 0; is_brk = 0; ext = 0;
      if (en) begin
         idle = 0;
         if (pend_brk) begin is_brk = 1; ext = pend_ext; pend_brk = 0; pend_ext = 0; end
         else if (b == 8'hF0) pend_brk = 1;
         else if (b == 8'hE0) begin if (EXT_EN) pend_ext = 1; end
         else begin is_make = 1; ext = pend_ext; pend_ext = 0; end
      end else if (pend_brk || pend_ext) begin
         idle++;
         if (idle == TMO) begin pend_brk = 0; pend_ext = 0; idle = 0; end
      end
      any = 0;
      for (int i = NK - 1; i >= 0; i--) begin
         code  = CODES[9*i +: 9];
         match = (b == code[7:0]) && (!EXT_EN || (ext == code[8]));
         hit   = match && (is_brk || (is_make && !m_down[i]));
         if (hit) begin
            m_down[i]  = is_make;
            m_state[i] = is_make ? 1 : 2;
            m_key      = i;
            any        = 1;
         end else if (c[i]) begin
            m_state[i] = 0;
         end
      end
      if (any) begin m_valid = 1; m_rel = is_brk; end
   endtask

   task automatic cycle(input bit r, input bit en, input logic [7:0] b, input logic [NK-1:0] c);
      rst = r; rd_en = en; rd = b; clr = c;
      @(posedge clk);
      model_step(r, en, b, c);
      @(negedge clk);
      rst = 0; rd_en = 0; clr = '0;
   endtask

   task automatic test_reset();
      cycle(1, 0, 8'h00, '0);
      cycle(1, 1, 8'h29, '0);
      total_cnt++;
      if ({ks, kd, ev_v, ev_k, ev_r} !== 16'h0000)
         $display("FAIL reset: got %h want %h", {ks, kd, ev_v, ev_k, ev_r}, 16'h0000);
      else pass_cnt++;
   endtask

   task automatic test_press();
      cycle(0, 1, 8'h29, '0);
      total_cnt++;
      if (ks[1:0] !== 2'd1 || kd[0] !== 1'b1 || ev_v !== 1'b1 || ev_k !== 2'd0 || ev_r !== 1'b0)
         $display("FAIL press: got ks=%h kd=%b v=%b k=%0d r=%b want slot0 pressed make event", ks, kd, ev_v, ev_k, ev_r);
      else pass_cnt++;
      cycle(0, 0, 8'h00, '0);
      total_cnt++;
      if ({ks, kd, ev_v, ev_k, ev_r} !== exp_vec())
         $display("FAIL press_pulse: got %h want %h", {ks, kd, ev_v, ev_k, ev_r}, exp_vec());
      else pass_cnt++;
   endtask

   task automatic test_typematic();
      int evs = 0;
      cycle(1, 0, 8'h00, '0);
      repeat (3) begin
         cycle(0, 1, 8'h29, '0);
         evs += int'(ev_v);
      end
      total_cnt++;
      if (evs !== 1 || ks[1:0] !== 2'd1)
         $display("FAIL typematic: got events=%0d state=%0d want events=1 state=1", evs, ks[1:0]);
      else pass_cnt++;
   endtask

   task automatic test_release();
      cycle(0, 1, 8'hF0, '0);
      cycle(0, 1, 8'h29, '0);
      total_cnt++;
      if (ks[1:0] !== 2'd2 || kd[0] !== 1'b0 || ev_v !== 1'b1 || ev_r !== 1'b1 || ev_k !== 2'd0)
         $display("FAIL release: got ks=%h kd=%b v=%b k=%0d r=%b want slot0 released break event", ks, kd, ev_v, ev_k, ev_r);
      else pass_cnt++;
   endtask

   task automatic test_extended();
      logic [7:0] seq[5] = '{8'hE0, 8'h75, 8'h75, 8'hF0, 8'h75};
      logic [1:0] want_slot1;
      cycle(0, 1, seq[0], '0);
      cycle(0, 1, seq[1], '0);
      total_cnt++;
      if (ks[3:2] !== 2'd1 || ev_v !== 1'b1 || ev_k !== 2'd1)
         $display("FAIL ext_press: got state=%0d v=%b k=%0d want state=1 v=1 k=1", ks[3:2], ev_v, ev_k);
      else pass_cnt++;
      for (int i = 2; i < 5; i++) begin
         cycle(0, 1, seq[i], '0);
         total_cnt++;
         if ({ks, kd, ev_v, ev_k, ev_r} !== exp_vec())
            $display("FAIL ext_seq%0d: got %h want %h", i, {ks, kd, ev_v, ev_k, ev_r}, exp_vec());
         else pass_cnt++;
      end
      want_slot1 = EXT_EN ? 2'd1 : 2'd2;
      total_cnt++;
      if (ks[3:2] !== want_slot1)
         $display("FAIL ext_plain: got state=%0d want %0d", ks[3:2], want_slot1);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      cycle(0, 1, 8'hF0, '0);
      repeat (TMO) cycle(0, 0, 8'h00, '0);
      cycle(0, 1, 8'h29, '0);
      total_cnt++;
      if (ks[1:0] !== 2'd1 || ev_r !== 1'b0 || ev_v !== 1'b1)
         $display("FAIL timeout_drop: got state=%0d v=%b r=%b want state=1 v=1 r=0", ks[1:0], ev_v, ev_r);
      else pass_cnt++;
      cycle(0, 1, 8'hF0, '0);
      repeat (TMO - 1) cycle(0, 0, 8'h00, '0);
      cycle(0, 1, 8'h29, '0);
      total_cnt++;
      if (ks[1:0] !== 2'd2 || ev_r !== 1'b1 || ev_v !== 1'b1)
         $display("FAIL timeout_edge: got state=%0d v=%b r=%b want state=2 v=1 r=1", ks[1:0], ev_v, ev_r);
      else pass_cnt++;
   endtask

   task automatic test_clear();
      cycle(0, 1, 8'h29, '0);
      cycle(0, 1, 8'hF0, '0);
      cycle(0, 1, 8'h29, 4'b0001);
      total_cnt++;
      if (ks[1:0] !== 2'd2 || ev_v !== 1'b1)
         $display("FAIL clear_race: got state=%0d v=%b want state=2 v=1", ks[1:0], ev_v);
      else pass_cnt++;
      cycle(0, 0, 8'h00, 4'b0001);
      total_cnt++;
      if (ks[1:0] !== 2'd0 || kd[0] !== 1'b0 || ev_v !== 1'b0)
         $display("FAIL clear_idle: got state=%0d kd=%b v=%b want 0 0 0", ks[1:0], kd[0], ev_v);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq[8] = '{8'h76, 8'h29, 8'hE0, 8'h72, 8'hF0, 8'h76, 8'h12, 8'hF0};
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, seq[i], 4'(i));
         total_cnt++;
         if ({ks, kd, ev_v, ev_k, ev_r} !== exp_vec())
            $display("FAIL b2b%0d: got %h want %h", i, {ks, kd, ev_v, ev_k, ev_r}, exp_vec());
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      cycle(0, 1, 8'hF0, '0);
      cycle(1, 0, 8'h00, '0);
      cycle(0, 1, 8'h29, '0);
      total_cnt++;
      if (ks[1:0] !== 2'd1 || ev_r !== 1'b0 || ev_v !== 1'b1)
         $display("FAIL reset_mid: got state=%0d v=%b r=%b want state=1 v=1 r=0", ks[1:0], ev_v, ev_r);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [7:0] pool[8] = '{8'hF0, 8'hE0, 8'h29, 8'h75, 8'h72, 8'h76, 8'h12, 8'h00};
      logic [7:0] b;
      logic [NK-1:0] c;
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            repeat ($urandom_range(95, 105)) begin
               cycle(0, 0, 8'h00, '0);
               total_cnt++;
               if ({ks, kd, ev_v, ev_k, ev_r} !== exp_vec())
                  $display("FAIL rand_idle%0d: got %h want %h", n, {ks, kd, ev_v, ev_k, ev_r}, exp_vec());
               else pass_cnt++;
            end
         end
         b = pool[$urandom_range(0, 7)];
         if (b == 8'h00) b = 8'($urandom);
         c = ($urandom_range(0, 3) == 0) ? NK'($urandom) : '0;
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, b, c);
         total_cnt++;
         if ({ks, kd, ev_v, ev_k, ev_r} !== exp_vec())
            $display("FAIL rand%0d: got %h want %h", n, {ks, kd, ev_v, ev_k, ev_r}, exp_vec());
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_typematic();
      test_release();
      test_extended();
      test_timeout();
      test_clear();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 key-event tracker that decodes the byte stream from `PS2_Controller` into per-key make/break state for a configurable set of keys. It handles break (`F0`) and extended (`E0`) prefixes, suppresses typematic repeats and times out stale prefixes. It raises a one-cycle event strobe per key transition. It sits between `PS2_Controller` and game/control logic, replacing single-key detection with N independently acknowledged key slots.

## Interface
- `NUM_KEYS`, 4: number of tracked key slots (1–16).
- `KEY_CODES`, {9'h076, 9'h172, 9'h175, 9'h029}: packed codes.
  - Slot i uses bits [9i+8:9i]; bit 8 is the extended flag and bits 7:0 are the scancode.
  - Defaults: slot0 Space, slot1 Up, slot2 Down, slot3 Esc.
  - `E0`/`F0` are illegal codes.
- `TIMEOUT_CYCLES`, 2_500_000: idle cycles after which a pending prefix is dropped (50 ms at 50 MHz). 0 disables the timeout.

Ports:
- `inclock` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `received_data` in 8: byte from `PS2_Controller`.
- `received_data_en` in 1: one-cycle strobe; the byte is valid this cycle.
- `state_clear` in NUM_KEYS: per-key acknowledge; returns `key_state` to IDLE.
- `key_state` out 2*NUM_KEYS: per-key state, IDLE=0, PRESSED=1, RELEASED=2.
- `key_down` out NUM_KEYS: per-key level, 1 while held.
- `event_valid` out 1: one-cycle pulse on any key transition.
- `event_key` out clog2(NUM_KEYS) (min 1): lowest matching slot index.
- `event_release` out 1: 1 = break, 0 = make.

## Operation
- Reset values:
  - parser in BASE;
  - all `key_state` = IDLE, `key_down` = 0;
  - `event_valid` = `event_key` = `event_release` = 0;
  - timeout counter = 0.
- The parser FSM advances only on `received_data_en`:
  - BASE: `F0` → BREAK; `E0` → EXT; any other byte is a make with ext=0, stay BASE.
  - EXT: `F0` → EXT_BREAK; `E0` → stay EXT; any other byte is a make with ext=1, → BASE.
  - BREAK / EXT_BREAK: the next byte is the break code with ext=0 or ext=1 respectively, → BASE. Prefix bytes received here match no slot.
- A slot matches when the code equals bits 7:0 and the ext flag equals bit 8.
- Make on a matching slot:
  - If `key_down`=0: set `key_down`=1, state=PRESSED, raise a make event.
  - If `key_down`=1: typematic repeat; no change, no event.
- Break on a matching slot: set `key_down`=0, state=RELEASED, raise a release event. This applies even if the key was not down.
- All matching slots update. `event_key` reports the lowest index.
- `state_clear[i]` sets slot i to IDLE. A same-cycle event on slot i wins over the clear; clears on other slots still apply.
- Timeout: the counter resets on every `received_data_en` and while in BASE. When it reaches `TIMEOUT_CYCLES`-1 in a non-BASE state, the parser returns to BASE with no key change.
- Unmatched bytes produce no event.

## Timing
- Byte strobe at cycle t: `key_state`, `key_down` and the event outputs are registered valid at t+1.
- `event_valid` is high for exactly one cycle; `event_key` and `event_release` are held until the next event.
- A `state_clear` asserted at t takes effect at t+1.
- Back-to-back strobes on consecutive cycles are supported; each byte is processed independently.
- Reset asserted mid-sequence (e.g. after `F0`) discards the prefix. Outputs take reset values at the next edge.
- Timeout boundary: a byte arriving in the same cycle the counter expires is processed in the prefix state. The byte wins.

## Configuration
- `PS2_KEY_EXTENDED_EN` defined:
  - `E0` handling as above;
  - bit 8 of `KEY_CODES` participates in matching.
- `PS2_KEY_EXTENDED_EN` undefined:
  - EXT and EXT_BREAK states are not built;
  - `E0` in BASE is ignored (stay BASE), and `E0` in BREAK is consumed as the code (matches nothing);
  - matching uses bits 7:0 only, so `E0 75` triggers the slot with code 175 via the plain `75`.

## Structure
- Shared package `ps2_pkg`:
  - `RELEASE_PREFIX`=8'hF0, `EXTEND_PREFIX`=8'hE0;
  - key-state encodings IDLE/PRESSED/RELEASED;
  - parser-state enum BASE/EXT/BREAK/EXT_BREAK.
- Sub-module `ps2_key_slot`, one instance per key via generate:
  - holds `key_down` and `key_state`;
  - inputs: match, make/break strobe, clear;
  - outputs: the per-slot event.
- The top level holds the parser FSM, the timeout counter and the lowest-index event priority encoder.

## Test plan
- Reset, then byte `29` → at t+1 slot0 PRESSED, `key_down`[0]=1, `event_valid`=1, `event_key`=0, `event_release`=0.
- Bytes `29`,`29`,`29` → exactly one event; state remains PRESSED.
- After the press, bytes `F0`,`29` → slot0 RELEASED, `key_down`[0]=0, one event with `event_release`=1.
- With the macro: `E0`,`75` → slot1 PRESSED, event `event_key`=1; a plain `75` then `F0 75` leaves slot1 PRESSED (no match).
- Byte `F0`, idle `TIMEOUT_CYCLES` cycles (set to 100), then `29` → treated as make, so slot0 PRESSED.
- `state_clear`[0] asserted in the same cycle as the strobe completing `F0 29` → slot0 RELEASED (event wins); clear held one more cycle → IDLE.
